// File: rtl/queue_fifo_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : queue_fifo_pkg
//  Brief   : Shared sizing constants and helpers for the queue_fifo slice.
//  Revision: 1.0  initial release
// ============================================================================
package queue_fifo_pkg;

  // Default entry width and pointer width used by the top and the bench.
  localparam int QUEUE_DATA_W = 8;
  localparam int QUEUE_ADDR_W = 4;

  // Number of entries addressed by a pointer of the given width.
  function automatic int depth_of(input int addr_w);
    return 1 << addr_w;
  endfunction

endpackage : queue_fifo_pkg
`default_nettype wire

// File: rtl/queue_fifo_if.sv
`default_nettype none
// ============================================================================
//  Module  : queue_fifo_if
//  Brief   : Strobe/data/status bundle between the button front end, the
//            queue and the display/LED path.
//  Revision: 1.0  initial release
// ============================================================================
interface queue_fifo_if
  import queue_fifo_pkg::*;
#(
  parameter int DATA_W = QUEUE_DATA_W,
  parameter int ADDR_W = QUEUE_ADDR_W
);

  logic              push;
  logic              pop;
  logic [DATA_W-1:0] din;
  logic [DATA_W-1:0] q;
  logic [DATA_W-1:0] head;
  logic [ADDR_W:0]   count;
  logic              full;
  logic              empty;
  logic              ovf;
  logic              unf;

  // Front end: issues strobes and data, observes queue status.
  modport master (
    output push, pop, din,
    input  q, head, count, full, empty, ovf, unf
  );

  // Queue: consumes strobes and data, drives status.
  modport slave (
    input  push, pop, din,
    output q, head, count, full, empty, ovf, unf
  );

endinterface : queue_fifo_if
`default_nettype wire

// File: rtl/queue_fifo_ram.sv
`default_nettype none
// ============================================================================
//  Module  : fifo_ram
//  Brief   : DEPTH x DATA_W register array, synchronous write, asynchronous
//            read. Contents are never reset.
//  Revision: 1.0  initial release
// ============================================================================
module fifo_ram
  import queue_fifo_pkg::*;
#(
  parameter int DATA_W = QUEUE_DATA_W,
  parameter int ADDR_W = QUEUE_ADDR_W
) (
  input  wire logic              clk,
  input  wire logic              we_i,
  input  wire logic [ADDR_W-1:0] waddr_i,
  input  wire logic [DATA_W-1:0] wdata_i,
  input  wire logic [ADDR_W-1:0] raddr_i,
  output      logic [DATA_W-1:0] rdata_o
);

  localparam int DEPTH = depth_of(ADDR_W);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Write port: store one entry on an enabled edge.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Read port is combinational so head can peek without a cycle of latency.
  assign rdata_o = mem_q[raddr_i];

endmodule : fifo_ram
`default_nettype wire

// File: rtl/queue_fifo.sv
`default_nettype none
// ============================================================================
//  Module  : queue_fifo
//  Brief   : 2**ADDR_W-entry FIFO queue driven by single-pulsed push/pop
//            strobes; exposes last dequeued value, head peek, count and
//            full/empty/overflow/underflow status.
//  Revision: 1.0  initial release
// ============================================================================
module queue_fifo
  import queue_fifo_pkg::*;
#(
  parameter int DATA_W = QUEUE_DATA_W,
  parameter int ADDR_W = QUEUE_ADDR_W
) (
  input wire logic clk,
  input wire logic clr,
  queue_fifo_if.slave bus
);

  localparam int DEPTH = depth_of(ADDR_W);

  localparam logic [ADDR_W:0]   CNT_DEPTH = DEPTH[ADDR_W:0];
  localparam logic [ADDR_W:0]   CNT_ONE   = 1;
  localparam logic [ADDR_W-1:0] PTR_ONE   = 1;

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q,  count_d;
  logic [DATA_W-1:0] q_q,      q_d;
  logic              ovf_q,    ovf_d;
  logic              unf_q,    unf_d;

  logic              full_w;
  logic              empty_w;
  logic              do_push_w;
  logic              do_pop_w;
  logic [DATA_W-1:0] rdata_w;

  // Status comes from the count only; pointer equality is ambiguous when full.
  assign full_w    = (count_q == CNT_DEPTH);
  assign empty_w   = (count_q == '0);
  // A push into a full queue is still accepted when a pop frees a slot.
  assign do_push_w = bus.push & (~full_w | bus.pop);
  assign do_pop_w  = bus.pop & ~empty_w;

  fifo_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .we_i    (do_push_w),
    .waddr_i (wr_ptr_q),
    .wdata_i (bus.din),
    .raddr_i (rd_ptr_q),
    .rdata_o (rdata_w)
  );

  // Next-state for pointers, occupancy, output register and error pulses.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    q_d      = q_q;
    ovf_d    = bus.push & full_w & ~bus.pop;
    unf_d    = bus.pop & empty_w;

    if (do_push_w) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (do_pop_w) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
      q_d      = rdata_w;
    end
    if (do_push_w && !do_pop_w) begin
      count_d = count_q + CNT_ONE;
    end else if (do_pop_w && !do_push_w) begin
      count_d = count_q - CNT_ONE;
    end
  end

  // State register; clr wins over any strobe on the same edge.
  always_ff @(posedge clk) begin
    if (clr) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      q_q      <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      q_q      <= q_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  assign bus.q     = q_q;
  assign bus.head  = empty_w ? '0 : rdata_w;
  assign bus.count = count_q;
  assign bus.full  = full_w;
  assign bus.empty = empty_w;
  assign bus.ovf   = ovf_q;
  assign bus.unf   = unf_q;

endmodule : queue_fifo
`default_nettype wire

// File: tb/tb_queue_fifo.sv
`default_nettype none
// ============================================================================
//  Module  : tb_queue_fifo
//  Brief   : Self-checking bench for queue_fifo using a data scoreboard.
//  Revision: 1.0  initial release
// ============================================================================
module tb_queue_fifo;
  import queue_fifo_pkg::*;

  localparam int DW    = QUEUE_DATA_W;
  localparam int AW    = QUEUE_ADDR_W;
  localparam int DEPTH = 1 << AW;

  logic clk = 1'b0;
  logic clr = 1'b0;

  queue_fifo_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  queue_fifo #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Entries believed to be in the queue, oldest first.
  logic [DW-1:0] sb[$];
  logic [DW-1:0] exp_q = '0;
  logic          exp_ovf = 1'b0;
  logic          exp_unf = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_status(input string tag);
    logic [DW-1:0] exp_head;
    exp_head = (sb.size() > 0) ? sb[0] : '0;
    check({tag, ".q"},     32'(bus.q),     32'(exp_q));
    check({tag, ".count"}, 32'(bus.count), 32'(sb.size()));
    check({tag, ".full"},  32'(bus.full),  32'(sb.size() == DEPTH));
    check({tag, ".empty"}, 32'(bus.empty), 32'(sb.size() == 0));
    check({tag, ".head"},  32'(bus.head),  32'(exp_head));
    check({tag, ".ovf"},   32'(bus.ovf),   32'(exp_ovf));
    check({tag, ".unf"},   32'(bus.unf),   32'(exp_unf));
  endtask

  // One clock of stimulus; scoreboard updated with the expected effect.
  task automatic op(input bit p, input bit o, input logic [DW-1:0] d, input string tag);
    int sz;
    bit dp;
    bit dpo;
    sz  = sb.size();
    dp  = p && (sz < DEPTH || o);
    dpo = o && (sz > 0);
    @(negedge clk);
    bus.push = p;
    bus.pop  = o;
    bus.din  = d;
    @(posedge clk);
    #1;
    bus.push = 1'b0;
    bus.pop  = 1'b0;
    exp_ovf = p && (sz == DEPTH) && !o;
    exp_unf = o && (sz == 0);
    if (dpo) exp_q = sb.pop_front();
    if (dp)  sb.push_back(d);
    check_status(tag);
  endtask

  task automatic do_clr(input int cycles, input bit p, input logic [DW-1:0] d, input string tag);
    @(negedge clk);
    clr      = 1'b1;
    bus.push = p;
    bus.din  = d;
    repeat (cycles) @(posedge clk);
    #1;
    clr      = 1'b0;
    bus.push = 1'b0;
    sb.delete();
    exp_q   = '0;
    exp_ovf = 1'b0;
    exp_unf = 1'b0;
    check_status(tag);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.push = 1'b0;
    bus.pop  = 1'b0;
    bus.din  = '0;

    // 1. reset
    do_clr(2, 1'b0, '0, "reset");

    // 2. basic order
    op(1, 0, 8'h11, "t2.push");
    op(1, 0, 8'h22, "t2.push");
    op(1, 0, 8'h33, "t2.push");
    op(0, 1, '0, "t2.pop1");
    check("t2.head_after_pop1", 32'(bus.head), 32'h22);
    op(0, 1, '0, "t2.pop2");
    op(0, 1, '0, "t2.pop3");
    check("t2.q_last", 32'(bus.q), 32'h33);

    // 3. fill to DEPTH, overflow, drain
    for (int i = 0; i < DEPTH; i++) op(1, 0, 8'(i), "t3.fill");
    op(1, 0, 8'hAA, "t3.ovf");
    check("t3.ovf_pulse", 32'(bus.ovf), 32'h1);
    op(0, 0, '0, "t3.idle");
    for (int i = 0; i < DEPTH; i++) begin
      op(0, 1, '0, "t3.drain");
      check("t3.drain_val", 32'(bus.q), 32'(i));
    end

    // 4. underflow keeps q
    op(0, 1, '0, "t4.unf");
    check("t4.q_held", 32'(bus.q), 32'h0F);
    op(0, 0, '0, "t4.idle");

    // 5a. full, push+pop together
    for (int i = 0; i < DEPTH; i++) op(1, 0, 8'(8'h80 + i), "t5.fill");
    op(1, 1, 8'h55, "t5.pushpop_full");
    check("t5.q_oldhead", 32'(bus.q), 32'h80);
    for (int i = 0; i < DEPTH; i++) op(0, 1, '0, "t5.drain");
    check("t5.last_is_55", 32'(bus.q), 32'h55);

    // 5b. empty, push+pop together
    op(1, 1, 8'h77, "t5.pushpop_empty");
    check("t5.head_77", 32'(bus.head), 32'h77);
    op(0, 1, '0, "t5.pop77");

    // 6. interleaved traffic across pointer wrap, then clr with push
    op(1, 0, 8'hC0, "t6.pre");
    op(1, 0, 8'hC1, "t6.pre");
    for (int i = 0; i < 40; i++) begin
      op(1, 0, 8'(i + 1), "t6.push");
      op(0, 1, '0, "t6.pop");
    end
    for (int i = 0; i < 10; i++) op(1, 1, 8'(8'hD0 + i), "t6.pair");
    do_clr(1, 1'b1, 8'hEE, "t6.clr_push");
    op(0, 1, '0, "t6.after_clr_pop");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule : tb_queue_fifo
`default_nettype wire
